// File: rtl/id_decode_pipe_pkg.sv
// id_decode_pipe_pkg: MIPS opcode/funct/rt constants, control-bundle field map and scoreboard state.
package id_decode_pipe_pkg;

    localparam int CTRL_W = 16;

    localparam int C_REGWRITE   = 0;
    localparam int C_REGDST     = 1;
    localparam int C_ALUSRC     = 2;
    localparam int C_BRANCH     = 3;
    localparam int C_MEMWRITE   = 4;
    localparam int C_MEMTOREG   = 5;
    localparam int C_JUMP       = 6;
    localparam int C_HILO_WE    = 7;
    localparam int C_HILO_RD    = 8;
    localparam int C_LINK       = 9;
    localparam int C_JR         = 10;
    localparam int C_MEM_SIGNED = 11;
    localparam int C_MEM_SIZE_LO = 12;
    localparam int C_MEM_SIZE_HI = 13;
    localparam int C_MDU_START  = 14;
    localparam int C_MDU_DIV    = 15;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F;
    localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR = 6'h08, F_JALR = 6'h09;
    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
    localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
    localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A, F_SLTU = 6'h2B;

    localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;

    typedef enum logic {SB_IDLE, SB_BUSY} sb_state_t;

    function automatic logic [1:0] mem_size(input logic [5:0] op);
        return (op == OP_LW || op == OP_SW) ? MEM_WORD :
               (op == OP_LH || op == OP_LHU || op == OP_SH) ? MEM_HALF : MEM_BYTE;
    endfunction

endpackage

// File: rtl/id_decode_pipe_dec_ctrl_lut.sv
// id_decode_pipe_dec_ctrl_lut: combinational op/rt/funct -> control bundle and reserved-instruction flag.
module id_decode_pipe_dec_ctrl_lut
    import id_decode_pipe_pkg::*;
(
    input  logic [5:0]        op,
    input  logic [4:0]        rt,
    input  logic [5:0]        funct,
    output logic [CTRL_W-1:0] ctrl,
    output logic              ri
);

    always_comb begin
        ctrl = '0;
        ri = 1'b0;
        case (op)
            OP_SPECIAL: case (funct)
                F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_ADD, F_ADDU, F_SUB, F_SUBU,
                F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: begin
                    ctrl[C_REGWRITE] = 1'b1;
                    ctrl[C_REGDST] = 1'b1;
                end
                F_JR: begin
                    ctrl[C_JUMP] = 1'b1;
                    ctrl[C_JR] = 1'b1;
                end
                F_JALR: begin
                    ctrl[C_JUMP] = 1'b1;
                    ctrl[C_JR] = 1'b1;
                    ctrl[C_LINK] = 1'b1;
                    ctrl[C_REGWRITE] = 1'b1;
                    ctrl[C_REGDST] = 1'b1;
                end
                F_MFHI, F_MFLO: begin
                    ctrl[C_HILO_RD] = 1'b1;
                    ctrl[C_REGWRITE] = 1'b1;
                    ctrl[C_REGDST] = 1'b1;
                end
                F_MTHI, F_MTLO: ctrl[C_HILO_WE] = 1'b1;
                F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                    ctrl[C_HILO_WE] = 1'b1;
                    ctrl[C_MDU_START] = 1'b1;
                    ctrl[C_MDU_DIV] = funct == F_DIV || funct == F_DIVU;
                end
                default: ;
            endcase
            OP_REGIMM: case (rt)
                RT_BLTZ, RT_BGEZ: ctrl[C_BRANCH] = 1'b1;
                RT_BLTZAL, RT_BGEZAL: begin
                    ctrl[C_BRANCH] = 1'b1;
                    ctrl[C_LINK] = 1'b1;
                    ctrl[C_REGWRITE] = 1'b1;
                end
                default: ri = 1'b1;
            endcase
            OP_J: ctrl[C_JUMP] = 1'b1;
            OP_JAL: begin
                ctrl[C_JUMP] = 1'b1;
                ctrl[C_LINK] = 1'b1;
                ctrl[C_REGWRITE] = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: ctrl[C_BRANCH] = 1'b1;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl[C_REGWRITE] = 1'b1;
                ctrl[C_ALUSRC] = 1'b1;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                ctrl[C_REGWRITE] = 1'b1;
                ctrl[C_ALUSRC] = 1'b1;
                ctrl[C_MEMTOREG] = 1'b1;
                ctrl[C_MEM_SIGNED] = op == OP_LB || op == OP_LH;
                ctrl[C_MEM_SIZE_HI:C_MEM_SIZE_LO] = mem_size(op);
            end
            OP_SB, OP_SH, OP_SW: begin
                ctrl[C_MEMWRITE] = 1'b1;
                ctrl[C_ALUSRC] = 1'b1;
                ctrl[C_MEM_SIZE_HI:C_MEM_SIZE_LO] = mem_size(op);
            end
            default: ri = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_decode_pipe.sv
// id_decode_pipe: registered, handshaked MIPS decode stage with a HILO/MDU scoreboard.
// Optional DEC_RI_EXC_EN adds the ri_exc output for reserved/unknown instructions.
module id_decode_pipe
    import id_decode_pipe_pkg::*;
#(
    parameter int DIV_CYCLES  = 32,
    parameter int MULT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [31:0]       in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              mdu_busy
`ifdef DEC_RI_EXC_EN
    ,
    output logic              ri_exc
`endif
);

    localparam int CNT_W = $clog2((DIV_CYCLES > MULT_CYCLES ? DIV_CYCLES : MULT_CYCLES) + 1);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MULT_CYCLES);

    logic [CTRL_W-1:0] dec_ctrl, ctrl_d;
    logic              dec_ri, hilo_stall, accept;
    sb_state_t         state;
    logic [CNT_W-1:0]  cnt;

    id_decode_pipe_dec_ctrl_lut u_lut (
        .op    (instr[31:26]),
        .rt    (instr[20:16]),
        .funct (instr[5:0]),
        .ctrl  (dec_ctrl),
        .ri    (dec_ri)
    );

`ifdef DEC_RI_EXC_EN
    localparam logic [CTRL_W-1:0] RI_KILL = CTRL_W'((1 << C_REGWRITE) | (1 << C_MEMWRITE) | (1 << C_MDU_START));
    assign ctrl_d = dec_ri ? (dec_ctrl & ~RI_KILL) : dec_ctrl;
`else
    assign ctrl_d = dec_ri ? '0 : dec_ctrl;
`endif

    // Stall looks at the next-state count so a waiter issues on the cycle the count reaches 0.
    assign hilo_stall = state == SB_BUSY && cnt > CNT_W'(1) && (dec_ctrl[C_HILO_WE] || dec_ctrl[C_HILO_RD]);
    assign in_ready   = !flush && (!out_valid || out_ready) && !hilo_stall;
    assign accept     = in_valid && in_ready;
    assign mdu_busy   = cnt != '0;

    // Flush deliberately leaves the scoreboard alone: the MDU op has already issued.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= SB_IDLE;
            cnt <= '0;
        end else if (accept && ctrl_d[C_MDU_START]) begin
            state <= SB_BUSY;
            cnt <= ctrl_d[C_MDU_DIV] ? DIV_LD : MUL_LD;
        end else if (state == SB_BUSY) begin
            cnt <= cnt - CNT_W'(1);
            state <= cnt == CNT_W'(1) ? SB_IDLE : SB_BUSY;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc <= '0;
            out_ctrl <= '0;
`ifdef DEC_RI_EXC_EN
            ri_exc <= 1'b0;
`endif
        end else if (accept) begin
            out_valid <= 1'b1;
            out_instr <= instr;
            out_pc <= in_pc;
            out_ctrl <= ctrl_d;
`ifdef DEC_RI_EXC_EN
            ri_exc <= dec_ri;
`endif
        end else if (flush || out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_decode_pipe.sv
// tb_id_decode_pipe: table-driven decode vectors plus hand-written scoreboard/handshake/flush/reset sequences.
module tb_id_decode_pipe;

    logic        clk = 1'b0;
    logic        resetn, flush, in_valid, in_ready, out_valid, out_ready, mdu_busy;
    logic [31:0] instr, in_pc, out_instr, out_pc;
    logic [15:0] out_ctrl;
`ifdef DEC_RI_EXC_EN
    logic        ri_exc;
`endif

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [31:0] I_DIV  = 32'h0022001A;
    localparam logic [31:0] I_MFLO = 32'h00001012;
    localparam logic [31:0] I_MFHI = 32'h00001010;
    localparam logic [31:0] I_ADDU = 32'h00221821;
    localparam logic [31:0] I_LW   = 32'h8C220004;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [15:0] ctrl;
        logic        ri;
    } vec_t;

    vec_t vecs[$];

    id_decode_pipe dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_ctrl  (out_ctrl),
        .mdu_busy  (mdu_busy)
`ifdef DEC_RI_EXC_EN
        ,
        .ri_exc    (ri_exc)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int waits;
        vecs.push_back({32'h3C011234, 32'h00001000, 16'h0005, 1'b0}); // LUI
        vecs.push_back({I_ADDU,       32'h00001004, 16'h0003, 1'b0});
        vecs.push_back({32'h34220005, 32'h00001008, 16'h0005, 1'b0}); // ORI
        vecs.push_back({I_LW,         32'h0000100C, 16'h2025, 1'b0});
        vecs.push_back({32'h80220000, 32'h00001010, 16'h0825, 1'b0}); // LB
        vecs.push_back({32'h84220000, 32'h00001014, 16'h1825, 1'b0}); // LH
        vecs.push_back({32'h90220000, 32'h00001018, 16'h0025, 1'b0}); // LBU
        vecs.push_back({32'h94220000, 32'h0000101C, 16'h1025, 1'b0}); // LHU
        vecs.push_back({32'hAC220004, 32'h00001020, 16'h2014, 1'b0}); // SW
        vecs.push_back({32'hA4220000, 32'h00001024, 16'h1014, 1'b0}); // SH
        vecs.push_back({32'hA0220000, 32'h00001028, 16'h0014, 1'b0}); // SB
        vecs.push_back({32'h10220003, 32'h0000102C, 16'h0008, 1'b0}); // BEQ
        vecs.push_back({32'h14220003, 32'h00001030, 16'h0008, 1'b0}); // BNE
        vecs.push_back({32'h1C200002, 32'h00001034, 16'h0008, 1'b0}); // BGTZ
        vecs.push_back({32'h04200002, 32'h00001038, 16'h0008, 1'b0}); // BLTZ
        vecs.push_back({32'h04310002, 32'h0000103C, 16'h0209, 1'b0}); // BGEZAL
        vecs.push_back({32'h08000010, 32'h00001040, 16'h0040, 1'b0}); // J
        vecs.push_back({32'h0C000010, 32'h00001044, 16'h0241, 1'b0}); // JAL
        vecs.push_back({32'h03E00008, 32'h00001048, 16'h0440, 1'b0}); // JR
        vecs.push_back({32'h0020F809, 32'h0000104C, 16'h0643, 1'b0}); // JALR
        vecs.push_back({32'hFC000000, 32'h00001050, 16'h0000, 1'b1}); // unknown op
        vecs.push_back({32'h04250000, 32'h00001054, 16'h0000, 1'b1}); // unknown REGIMM rt
        vecs.push_back({I_MFHI,       32'h00001058, 16'h0103, 1'b0});
        vecs.push_back({32'h00200013, 32'h0000105C, 16'h0080, 1'b0}); // MTLO
        vecs.push_back({32'h00220018, 32'h00001060, 16'h4080, 1'b0}); // MULT
        vecs.push_back({32'h0022001B, 32'h00001064, 16'hC080, 1'b0}); // DIVU right behind 1-cycle MULT

        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = '0; in_pc = '0;
        repeat (2) tick();
        check("reset_state", {out_valid, mdu_busy, out_ctrl, out_pc}, '0);
        check("reset_instr", {32'h0, out_instr}, '0);
        resetn = 1'b1;
        tick();

        foreach (vecs[i]) begin
            instr = vecs[i].instr;
            in_pc = vecs[i].pc;
            in_valid = 1'b1;
            tick();
            #1;
            check($sformatf("vec%0d", i), {out_valid, out_ctrl, out_pc}, {1'b1, vecs[i].ctrl, vecs[i].pc});
`ifdef DEC_RI_EXC_EN
            check($sformatf("vec%0d_ri", i), {63'h0, ri_exc}, {63'h0, vecs[i].ri});
`endif
        end
        in_valid = 1'b0;
        for (int k = 0; k < 40 && mdu_busy; k++) tick();
        check("divu_drain", {63'h0, mdu_busy}, 64'h0);

        // DIV, one free-flowing ADDU, then MFLO waits on the scoreboard
        instr = I_DIV; in_valid = 1'b1; #1;
        check("div_rdy", {63'h0, in_ready}, 64'h1);
        tick();
        instr = I_ADDU; #1;
        check("div_busy", {47'h0, mdu_busy, out_ctrl}, {47'h0, 1'b1, 16'hC080});
        check("addu_flows", {63'h0, in_ready}, 64'h1);
        tick();
        instr = I_MFLO; #1;
        check("addu_out", {48'h0, out_ctrl}, 64'h0003);
        waits = 0;
        for (int k = 0; k < 40 && !in_ready; k++) begin
            waits++;
            tick();
            #1;
        end
        check("mflo_stall_cycles", 64'(waits), 64'd30);
        tick();
        in_valid = 1'b0; #1;
        check("mflo_out", {47'h0, mdu_busy, out_ctrl}, {47'h0, 1'b0, 16'h0103});

        // LW held by backpressure
        instr = I_LW; in_valid = 1'b1;
        tick();
        instr = I_ADDU; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("lw_hold%0d", k), {46'h0, in_ready, out_valid, out_ctrl}, {46'h0, 1'b0, 1'b1, 16'h2025});
            tick();
        end
        out_ready = 1'b1; #1;
        check("lw_release_rdy", {63'h0, in_ready}, 64'h1);
        tick();
        #1;
        check("lw_release_out", {47'h0, out_valid, out_ctrl}, {47'h0, 1'b1, 16'h0003});

        // flush after DIV issue
        instr = I_DIV;
        tick();
        flush = 1'b1; instr = I_ADDU; #1;
        check("flush_rdy", {63'h0, in_ready}, 64'h0);
        tick();
        flush = 1'b0; #1;
        check("flush_out", {62'h0, out_valid, mdu_busy}, {62'h0, 1'b0, 1'b1});
        check("flush_hold_div", {48'h0, out_ctrl}, 64'hC080);
        repeat (21) tick();
        #1;
        check("pre_reset", {62'h0, out_valid, mdu_busy}, {62'h0, 1'b1, 1'b1});

        // asynchronous reset mid-DIV, count 10
        resetn = 1'b0; #1;
        check("async_reset", {46'h0, out_valid, mdu_busy, out_ctrl}, '0);
        tick();
        resetn = 1'b1;
        instr = I_MFHI; #1;
        check("mfhi_after_reset_rdy", {63'h0, in_ready}, 64'h1);
        tick();
        in_valid = 1'b0; #1;
        check("mfhi_after_reset_out", {47'h0, out_valid, out_ctrl}, {47'h0, 1'b1, 16'h0103});
        tick();
        check("drain", {63'h0, out_valid}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
